// File: rtl/cvxif_copro_router.sv
// CV-X-IF router: broadcasts CPU issues to NR_COPRO coprocessors, tracks ID ownership,
// routes commits to the owner and round-robin merges results. Optional accept counters: CVXIF_ROUTER_PERF_EN.
module cvxif_copro_router #(
    parameter int unsigned NR_COPRO = 2,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [ID_W-1:0]          issue_id_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    input  logic                     commit_valid_i,
    input  logic [ID_W-1:0]          commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_W-1:0]          result_id_o,
    output logic [XLEN-1:0]          result_data_o,
    output logic [4:0]               result_rd_o,
    output logic                     result_we_o,
    output logic [NR_COPRO-1:0]      cp_issue_valid_o,
    input  logic [NR_COPRO-1:0]      cp_issue_ready_i,
    input  logic [NR_COPRO-1:0]      cp_issue_accept_i,
    input  logic [NR_COPRO-1:0]      cp_issue_writeback_i,
    output logic [NR_COPRO-1:0]      cp_commit_valid_o,
    output logic [ID_W-1:0]          cp_commit_id_o,
    output logic                     cp_commit_kill_o,
    input  logic [NR_COPRO-1:0]      cp_result_valid_i,
    output logic [NR_COPRO-1:0]      cp_result_ready_o,
    input  logic [NR_COPRO*ID_W-1:0] cp_result_id_i,
    input  logic [NR_COPRO*XLEN-1:0] cp_result_data_i,
    input  logic [NR_COPRO*5-1:0]    cp_result_rd_i,
    input  logic [NR_COPRO-1:0]      cp_result_we_i,
    output logic                     err_multi_accept_o,
    output logic [NR_COPRO*16-1:0]   perf_cnt_o
);

    localparam int unsigned DEPTH = 2**ID_W;
    localparam int unsigned IDX_W = (NR_COPRO > 1) ? $clog2(NR_COPRO) : 1;
    localparam int unsigned CNT_W = 4;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] wb;
    logic [IDX_W-1:0] owner [DEPTH];
    logic [IDX_W-1:0] rr_ptr;

    logic             issue_free_c;
    logic             issue_hs_c;
    logic [CNT_W-1:0] acc_cnt_c;
    logic [IDX_W-1:0] acc_idx_c;
    logic             single_c;
    logic             multi_c;
    logic             commit_hit_c;
    logic             commit_clr_c;
    logic [IDX_W-1:0] grant_c;
    logic             grant_vld_c;
    logic             cp_load_c;
    logic             cpu_hs_c;

    // Issue side: broadcast and accept decode
    always_comb begin
        acc_cnt_c = '0;
        acc_idx_c = '0;
        for (int unsigned k = 0; k < NR_COPRO; k++) begin
            if (cp_issue_accept_i[k]) begin
                acc_cnt_c = acc_cnt_c + CNT_W'(1);
                acc_idx_c = IDX_W'(k);
            end
        end
    end

    assign single_c          = (acc_cnt_c == CNT_W'(1));
    assign multi_c           = (acc_cnt_c > CNT_W'(1));
    assign issue_free_c      = ~busy[issue_id_i];
    assign issue_ready_o     = issue_free_c & (&cp_issue_ready_i);
    assign cp_issue_valid_o  = {NR_COPRO{issue_valid_i & issue_free_c}};
    assign issue_accept_o    = single_c;
    assign issue_writeback_o = single_c & cp_issue_writeback_i[acc_idx_c];
    assign issue_hs_c        = issue_valid_i & issue_ready_o;

    // Commit routing to the recorded owner only
    assign commit_hit_c      = commit_valid_i & busy[commit_id_i];
    assign cp_commit_valid_o = commit_hit_c ? (NR_COPRO'(1) << owner[commit_id_i]) : '0;
    assign cp_commit_id_o    = commit_id_i;
    assign cp_commit_kill_o  = commit_kill_i;
    assign commit_clr_c      = commit_hit_c & (commit_kill_i | ~wb[commit_id_i]);

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int unsigned i = 0; i < NR_COPRO; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NR_COPRO;
            if (!grant_vld_c && cp_result_valid_i[idx]) begin
                grant_vld_c = 1'b1;
                grant_c     = IDX_W'(idx);
            end
        end
    end

    assign cp_load_c         = grant_vld_c & (~result_valid_o | result_ready_i);
    assign cp_result_ready_o = cp_load_c ? (NR_COPRO'(1) << grant_c) : '0;
    assign cpu_hs_c          = result_valid_o & result_ready_i;

    // One-entry result output register and arbitration pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
            rr_ptr         <= '0;
        end else if (cp_load_c) begin
            result_valid_o <= 1'b1;
            result_id_o    <= cp_result_id_i[32'(grant_c)*ID_W +: ID_W];
            result_data_o  <= cp_result_data_i[32'(grant_c)*XLEN +: XLEN];
            result_rd_o    <= cp_result_rd_i[32'(grant_c)*5 +: 5];
            result_we_o    <= cp_result_we_i[grant_c];
            rr_ptr         <= (grant_c == IDX_W'(NR_COPRO-1)) ? '0 : grant_c + IDX_W'(1);
        end else if (result_ready_i) begin
            result_valid_o <= 1'b0;
        end
    end

    // Ownership table; the issue set is last so it wins over same-ID clears
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy               <= '0;
            wb                 <= '0;
            err_multi_accept_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                owner[i] <= '0;
            end
        end else begin
            if (commit_clr_c) begin
                busy[commit_id_i] <= 1'b0;
            end
            if (cpu_hs_c) begin
                busy[result_id_o] <= 1'b0;
            end
            if (issue_hs_c && single_c) begin
                busy[issue_id_i]  <= 1'b1;
                owner[issue_id_i] <= acc_idx_c;
                wb[issue_id_i]    <= cp_issue_writeback_i[acc_idx_c];
            end
            if (issue_hs_c && multi_c) begin
                err_multi_accept_o <= 1'b1;
            end
        end
    end

`ifdef CVXIF_ROUTER_PERF_EN
    logic [15:0] perf_q [NR_COPRO];

    // Saturating per-coprocessor accept counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NR_COPRO; k++) begin
                perf_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NR_COPRO; k++) begin
                if (issue_hs_c && single_c && (acc_idx_c == IDX_W'(k)) && (perf_q[k] != 16'hFFFF)) begin
                    perf_q[k] <= perf_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        perf_cnt_o = '0;
        for (int unsigned k = 0; k < NR_COPRO; k++) begin
            perf_cnt_o[k*16 +: 16] = perf_q[k];
        end
    end
`else
    assign perf_cnt_o = '0;
`endif

endmodule
